truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 146 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks all eight {a,b,c} input vectors of a 3-input
// combinational unit, holds each vector for SETTLE_CYCLES+1 cycles, captures
// the unit's p/q responses and compares them against latched expectations.
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expect_p,
  input  logic [7:0] expect_q,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_p,
  input  logic       dut_q,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_p,
  output logic [7:0] table_q,
  output logic [7:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_vec;
  logic [7:0] r_expP;
  logic [7:0] r_expQ;
  logic [7:0] r_tableP;
  logic [7:0] r_tableQ;
  logic [7:0] r_failMask;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic [7:0] w_tablePNext;
  logic [7:0] w_tableQNext;
  logic [7:0] w_failNext;
  logic       w_sampleNow;

  assign w_sampleNow = (r_cnt == 4'(SETTLE_CYCLES));

  // Tables as they will look once the current vector's response is written, so the final verdict includes the last sample.
  always_comb begin
    w_tablePNext        = r_tableP;
    w_tableQNext        = r_tableQ;
    w_tablePNext[r_idx] = dut_p;
    w_tableQNext[r_idx] = dut_q;
    w_failNext          = (w_tablePNext ^ r_expP) | (w_tableQNext ^ r_expQ);
  end

  // Sequencer FSM: vector stepping, settle counting, capture and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= 4'd0;
      r_vec      <= 3'd0;
      r_expP     <= 8'h00;
      r_expQ     <= 8'h00;
      r_tableP   <= 8'h00;
      r_tableQ   <= 8'h00;
      r_failMask <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= RUN;
            r_idx      <= 3'd0;
            r_cnt      <= 4'd0;
            r_vec      <= 3'd0;
            r_expP     <= expect_p;
            r_expQ     <= expect_q;
            r_tableP   <= 8'h00;
            r_tableQ   <= 8'h00;
            r_failMask <= 8'h00;
            r_pass     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_vec   <= 3'd0;
            r_busy  <= 1'b0;
          end else if (w_sampleNow) begin
            r_tableP <= w_tablePNext;
            r_tableQ <= w_tableQNext;
            if (r_idx == 3'd7) begin
              r_state    <= DONE;
              r_idx      <= 3'd0;
              r_cnt      <= 4'd0;
              r_vec      <= 3'd0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_failMask <= w_failNext;
              r_pass     <= (w_failNext == 8'h00);
            end else begin
              r_idx <= r_idx + 3'd1;
              r_vec <= r_idx + 3'd1;
              r_cnt <= 4'd0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_vec   <= 3'd0;
        end
      endcase
    end
  end

  assign dut_a     = r_vec[2];
  assign dut_b     = r_vec[1];
  assign dut_c     = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign table_p   = r_tableP;
  assign table_q   = r_tableQ;
  assign fail_mask = r_failMask;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: drives the sequencer against a modelled unit
// p = a&b, q = (a&b)|c and checks vector stepping and verdicts through a
// scoreboard of expected vectors and expected end-of-pass results.
module tb_truth_table_sequencer;

  localparam int SETTLE = 2;
  localparam int PASS_LEN = 8 * (SETTLE + 1);

  typedef struct {
    logic [7:0] tp;
    logic [7:0] tq;
    logic [7:0] mask;
    logic       pass;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] expect_p;
  logic [7:0] expect_q;
  logic       dut_a, dut_b, dut_c;
  logic       dut_p, dut_q;
  logic       busy, done, pass;
  logic [7:0] table_p, table_q, fail_mask;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [2:0] vecQ[$];
  res_t       resQ[$];

  // The combinational unit under test, modelled directly.
  assign dut_p = dut_a & dut_b;
  assign dut_q = (dut_a & dut_b) | dut_c;

  truth_table_sequencer #(.SETTLE_CYCLES(SETTLE)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .expect_p  (expect_p),
    .expect_q  (expect_q),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_c     (dut_c),
    .dut_p     (dut_p),
    .dut_q     (dut_q),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .table_p   (table_p),
    .table_q   (table_q),
    .fail_mask (fail_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Queue the vector sequence and the verdict a full pass should produce.
  task automatic push_pass(input logic [7:0] ep, input logic [7:0] eq);
    res_t r;
    logic [2:0] v;
    r.tp = 8'h00;
    r.tq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      r.tp[i] = v[2] & v[1];
      r.tq[i] = (v[2] & v[1]) | v[0];
      for (int s = 0; s <= SETTLE; s++) vecQ.push_back(v);
    end
    r.mask = (r.tp ^ ep) | (r.tq ^ eq);
    r.pass = (r.mask == 8'h00);
    resQ.push_back(r);
  endtask

  // Walk a pass from its first RUN cycle to its DONE cycle, popping the scoreboard.
  task automatic run_pass(input logic changeMid, input string tag);
    logic [2:0] v;
    res_t r;
    for (int k = 0; k < PASS_LEN; k++) begin
      v = (vecQ.size() > 0) ? vecQ.pop_front() : 3'd0;
      nCompared++;
      if ({busy, done, dut_a, dut_b, dut_c} !== {1'b1, 1'b0, v}) begin
        nMismatched++;
        $display("[TB] FAIL %s_run k=%0d got busy=%b done=%b abc=%b%b%b want busy=1 done=0 abc=%b",
                 tag, k, busy, done, dut_a, dut_b, dut_c, v);
      end
      if (changeMid && k == 10) expect_p = ~expect_p;
      tick;
    end
    if (resQ.size() > 0) r = resQ.pop_front();
    else begin
      r.tp = 8'hxx; r.tq = 8'hxx; r.mask = 8'hxx; r.pass = 1'bx;
    end
    nCompared++;
    if ({done, busy, dut_a, dut_b, dut_c} !== 5'b10000) begin
      nMismatched++;
      $display("[TB] FAIL %s_done got done=%b busy=%b abc=%b%b%b want done=1 busy=0 abc=000",
               tag, done, busy, dut_a, dut_b, dut_c);
    end
    nCompared++;
    if (table_p !== r.tp || table_q !== r.tq) begin
      nMismatched++;
      $display("[TB] FAIL %s_tables got p=%h q=%h want p=%h q=%h", tag, table_p, table_q, r.tp, r.tq);
    end
    nCompared++;
    if (pass !== r.pass || fail_mask !== r.mask) begin
      nMismatched++;
      $display("[TB] FAIL %s_verdict got pass=%b mask=%h want pass=%b mask=%h",
               tag, pass, fail_mask, r.pass, r.mask);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    expect_p = 8'h00; expect_q = 8'h00;
    #12;
    nCompared++;
    if ({busy, done, pass, dut_a, dut_b, dut_c} !== 6'b000000) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl got busy=%b done=%b pass=%b abc=%b%b%b want all 0",
               busy, done, pass, dut_a, dut_b, dut_c);
    end
    nCompared++;
    if (table_p !== 8'h00 || table_q !== 8'h00 || fail_mask !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL reset_tables got p=%h q=%h mask=%h want 00 00 00", table_p, table_q, fail_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    expect_p = 8'hC0; expect_q = 8'hEA;
    push_pass(8'hC0, 8'hEA);
    start = 1'b1;
    tick;
    start = 1'b0;
    run_pass(1'b0, "basic");
    tick;
    nCompared++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL basic_after got done=%b busy=%b pass=%b want 0 0 1", done, busy, pass);
    end
  endtask

  task automatic test_fail_mask;
    expect_p = 8'hC0; expect_q = 8'hEB;
    push_pass(8'hC0, 8'hEB);
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    run_pass(1'b1, "failmask");
    tick;
  endtask

  task automatic test_abort;
    expect_p = 8'hC0; expect_q = 8'hEA;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int j = 1; j < 10; j++) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    nCompared++;
    if ({busy, done, dut_a, dut_b, dut_c} !== 5'b00000) begin
      nMismatched++;
      $display("[TB] FAIL abort_ctrl got busy=%b done=%b abc=%b%b%b want 0 0 000",
               busy, done, dut_a, dut_b, dut_c);
    end
    nCompared++;
    if (table_p !== 8'h00 || table_q !== 8'h02 || pass !== 1'b0 || fail_mask !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL abort_tables got p=%h q=%h pass=%b mask=%h want 00 02 0 00",
               table_p, table_q, pass, fail_mask);
    end
    for (int j = 0; j < 5; j++) begin
      tick;
      nCompared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL abort_nodone cyc=%0d got done=%b busy=%b want 0 0", j, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    expect_p = 8'hC0; expect_q = 8'hEA;
    push_pass(8'hC0, 8'hEA);
    start = 1'b1;
    tick;
    run_pass(1'b0, "b2b_first");
    push_pass(8'hC0, 8'hEA);
    tick;
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_gap got busy=%b done=%b want 0 0", busy, done);
    end
    tick;
    run_pass(1'b0, "b2b_second");
    start = 1'b0;
    tick;
    tick;
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_stop got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] v;
    expect_p = 8'hC0; expect_q = 8'hEA;
    push_pass(8'hC0, 8'hEA);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      v = (vecQ.size() > 0) ? vecQ.pop_front() : 3'd0;
      nCompared++;
      if ({busy, dut_a, dut_b, dut_c} !== {1'b1, v}) begin
        nMismatched++;
        $display("[TB] FAIL rstmid_run k=%0d got busy=%b abc=%b%b%b want busy=1 abc=%b",
                 k, busy, dut_a, dut_b, dut_c, v);
      end
      tick;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecQ.delete();
    resQ.delete();
    nCompared++;
    if ({busy, done, pass, dut_a, dut_b, dut_c} !== 6'b000000 || table_p !== 8'h00 ||
        table_q !== 8'h00 || fail_mask !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_async got busy=%b done=%b abc=%b%b%b p=%h q=%h want all 0",
               busy, done, dut_a, dut_b, dut_c, table_p, table_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick;
      nCompared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL rstmid_nodone cyc=%0d got done=%b busy=%b want 0 0", j, done, busy);
      end
    end
    push_pass(8'hC0, 8'hEA);
    start = 1'b1;
    tick;
    start = 1'b0;
    run_pass(1'b0, "rstmid_rerun");
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fail_mask;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
